// File: rtl/program_memory_responder_pkg.sv
// Shared constants and types for the program memory responder.
//   NOP_INSTRUCTION    : word returned on fetch while the core is held or out of range
//   MMIO_*_OFFSET      : byte offsets of the MMIO registers from MMIO_BASE
//   loader_state_t     : boot loader phase (streaming image in / core running)
package program_memory_responder_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  localparam int unsigned MMIO_OUT_OFFSET    = 0;
  localparam int unsigned MMIO_STATUS_OFFSET = 4;

  typedef enum logic [0:0] {
    LOADER_LOAD = 1'b0,
    LOADER_RUN  = 1'b1
  } loader_state_t;

endpackage

// File: rtl/program_memory_responder_mmio_output_register.sv
// One-entry MMIO output holding register with a valid/ready drain.
//   clk, n_rst          : clock, synchronous active-low reset
//   i_push, i_push_data : store to the output register
//   i_ready             : sink consumes the held word
//   o_valid, o_data     : held word, stable until consumed
//   o_overflow          : sticky flag, a push arrived while full and was dropped
module mmio_output_register #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_push_data,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_data,
  output logic            o_overflow
);

  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic            r_overflow;

  logic w_pop;
  logic w_capture;
  logic w_drop;

  assign w_pop     = r_valid & i_ready;
  // A pop in the same cycle frees the slot, so the push can land immediately.
  assign w_capture = i_push & (~r_valid | i_ready);
  assign w_drop    = i_push & r_valid & ~i_ready;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        r_valid <= 1'b1;
        r_data  <= i_push_data;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/program_memory_responder.sv
// Memory-side responder for a single-cycle core: unified word-addressed RAM,
// boot loader that streams an image in while holding the core in reset, and
// one MMIO output register with a valid/ready drain.
//   clk, n_rst                        : clock, synchronous active-low reset
//   load_valid/ready/data/last        : boot image stream
//   core_n_rst                        : registered reset to the core (high in RUN)
//   program_counter, instruction      : combinational fetch port
//   memory_write_enable/address/
//   memory_write_data/read_data       : data port, stores commit at posedge
//   mmio_out_valid/ready/data         : output register drain
//   mmio_overflow                     : sticky dropped-store flag
module program_memory_responder
  import program_memory_responder_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] MMIO_BASE   = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_last,
  output logic            core_n_rst,
  input  logic [XLEN-1:0] program_counter,
  output logic [31:0]     instruction,
  input  logic            memory_write_enable,
  input  logic [XLEN-1:0] memory_address,
  input  logic [XLEN-1:0] memory_write_data,
  output logic [XLEN-1:0] memory_read_data,
  output logic            mmio_out_valid,
  input  logic            mmio_out_ready,
  output logic [XLEN-1:0] mmio_out_data,
  output logic            mmio_overflow
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [XLEN-1:0] MMIO_OUT_ADDR    = MMIO_BASE + XLEN'(MMIO_OUT_OFFSET);
  localparam logic [XLEN-1:0] MMIO_STATUS_ADDR = MMIO_BASE + XLEN'(MMIO_STATUS_OFFSET);
  localparam logic [IDX_W-1:0] LAST_PTR        = IDX_W'(DEPTH_WORDS - 1);

  // RAM is deliberately not reset so that a reload keeps untouched words.
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  loader_state_t    r_state;
  logic [IDX_W-1:0] r_load_ptr;
  logic             r_core_n_rst;

  logic             w_run;
  logic             w_load_fire;
  logic             w_load_done;
  logic [IDX_W-1:0] w_data_idx;
  logic             w_data_in_range;
  logic [IDX_W-1:0] w_pc_idx;
  logic             w_pc_in_range;
  logic             w_store;
  logic             w_ram_we;
  logic [IDX_W-1:0] w_ram_waddr;
  logic [XLEN-1:0]  w_ram_wdata;
  logic [XLEN-1:0]  w_fetch_word;
  logic             w_mmio_push;
  logic             w_mmio_valid;
  logic             w_mmio_overflow;
  logic [XLEN-1:0]  w_mmio_data;
  logic             w_unused;

  // Sub-word address bits are architecturally ignored.
  assign w_unused = ^{program_counter[1:0], memory_address[1:0]};

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign w_data_idx      = memory_address[IDX_W+1:2];
  assign w_data_in_range = (memory_address[XLEN-1:IDX_W+2] == '0);
  assign w_pc_idx        = program_counter[IDX_W+1:2];
  assign w_pc_in_range   = (program_counter[XLEN-1:IDX_W+2] == '0);

  // ---------------------------------------------------------------------------
  // Boot loader FSM
  // ---------------------------------------------------------------------------
  assign w_run       = (r_state == LOADER_RUN);
  assign load_ready  = (r_state == LOADER_LOAD);
  assign w_load_fire = load_ready & load_valid;
  // Filling the last word ends the load even without load_last.
  assign w_load_done = w_load_fire & (load_last | (r_load_ptr == LAST_PTR));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state      <= LOADER_LOAD;
      r_load_ptr   <= '0;
      r_core_n_rst <= 1'b0;
    end else if (w_load_fire) begin
      r_load_ptr <= r_load_ptr + 1'b1;
      if (w_load_done) begin
        r_state      <= LOADER_RUN;
        r_core_n_rst <= 1'b1;
      end
    end
  end

  assign core_n_rst = r_core_n_rst;

  // ---------------------------------------------------------------------------
  // RAM write port: loader beats in LOAD, core stores in RUN (never both).
  // ---------------------------------------------------------------------------
  assign w_store     = w_run & memory_write_enable;
  assign w_ram_we    = w_load_fire | (w_store & w_data_in_range);
  assign w_ram_waddr = w_load_fire ? r_load_ptr : w_data_idx;
  assign w_ram_wdata = w_load_fire ? load_data : memory_write_data;

  always_ff @(posedge clk) begin
    if (n_rst && w_ram_we) begin
      r_mem[w_ram_waddr] <= w_ram_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch: NOP while the core is held or the PC is outside the RAM.
  // ---------------------------------------------------------------------------
  assign w_fetch_word = r_mem[w_pc_idx];
  assign instruction  = (w_run && w_pc_in_range) ? w_fetch_word[31:0] : NOP_INSTRUCTION;

  // ---------------------------------------------------------------------------
  // MMIO output register
  // ---------------------------------------------------------------------------
  assign w_mmio_push = w_store & (memory_address == MMIO_OUT_ADDR);

  mmio_output_register #(
    .XLEN (XLEN)
  ) u_mmio_out (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_push      (w_mmio_push),
    .i_push_data (memory_write_data),
    .i_ready     (mmio_out_ready),
    .o_valid     (w_mmio_valid),
    .o_data      (w_mmio_data),
    .o_overflow  (w_mmio_overflow)
  );

  assign mmio_out_valid = w_mmio_valid;
  assign mmio_out_data  = w_mmio_data;
  assign mmio_overflow  = w_mmio_overflow;

  // ---------------------------------------------------------------------------
  // Data read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    memory_read_data = '0;
    if (w_data_in_range) begin
      memory_read_data = r_mem[w_data_idx];
    end else if (memory_address == MMIO_OUT_ADDR) begin
      memory_read_data = w_mmio_data;
    end else if (memory_address == MMIO_STATUS_ADDR) begin
      memory_read_data = {{(XLEN-2){1'b0}}, w_mmio_overflow, w_mmio_valid};
    end
  end

endmodule

// File: tb/tb_program_memory_responder.sv
// Directed self-checking bench for program_memory_responder.
module tb_program_memory_responder;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        core_n_rst;
  logic [31:0] program_counter;
  logic [31:0] instruction;
  logic        memory_write_enable;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        mmio_out_valid;
  logic        mmio_out_ready;
  logic [31:0] mmio_out_data;
  logic        mmio_overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  program_memory_responder #(
    .XLEN        (32),
    .DEPTH_WORDS (1024),
    .MMIO_BASE   (MMIO_BASE)
  ) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .load_valid          (load_valid),
    .load_ready          (load_ready),
    .load_data           (load_data),
    .load_last           (load_last),
    .core_n_rst          (core_n_rst),
    .program_counter     (program_counter),
    .instruction         (instruction),
    .memory_write_enable (memory_write_enable),
    .memory_address      (memory_address),
    .memory_write_data   (memory_write_data),
    .memory_read_data    (memory_read_data),
    .mmio_out_valid      (mmio_out_valid),
    .mmio_out_ready      (mmio_out_ready),
    .mmio_out_data       (mmio_out_data),
    .mmio_overflow       (mmio_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge; inputs change here.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    memory_address = addr;
    #1;
    check_eq(tag, memory_read_data, exp);
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    program_counter = pc;
    #1;
    check_eq(tag, instruction, exp);
  endtask

  // Backpressured image: bubbles carry junk data and a stray last that must be ignored.
  logic        bp_valid [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] bp_data  [7] = '{32'h1111_1111, 32'hBAD0_0000, 32'h2222_2222, 32'hBAD0_0001,
                                32'h3333_3333, 32'hBAD0_0002, 32'h4444_4444};
  logic        bp_last  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] prog     [3] = '{32'h0010_0093, 32'h0000_0013, 32'h0000_006F};

  initial begin
    n_rst               = 1'b0;
    load_valid          = 1'b0;
    load_data           = '0;
    load_last           = 1'b0;
    program_counter     = '0;
    memory_write_enable = 1'b0;
    memory_address      = MMIO_BASE + 32'd4;
    memory_write_data   = '0;
    mmio_out_ready      = 1'b0;

    // Reset state
    repeat (2) tick();
    check_eq("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check_eq("rst_core_n_rst", {31'b0, core_n_rst}, 32'd0);
    check_eq("rst_out_valid", {31'b0, mmio_out_valid}, 32'd0);
    check_eq("rst_out_data", mmio_out_data, 32'd0);
    check_eq("rst_overflow", {31'b0, mmio_overflow}, 32'd0);
    check_eq("rst_status", memory_read_data, 32'd0);
    check_eq("rst_fetch_nop", instruction, NOP);

    // Backpressured load of 4 words
    n_rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check_eq("bp_ready", {31'b0, load_ready}, 32'd1);
      load_valid = bp_valid[i];
      load_data  = bp_data[i];
      load_last  = bp_last[i];
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    #1;
    check_eq("bp_ready_low", {31'b0, load_ready}, 32'd0);
    check_eq("bp_core_run", {31'b0, core_n_rst}, 32'd1);
    rd("bp_w0", 32'h0, 32'h1111_1111);
    rd("bp_w1", 32'h4, 32'h2222_2222);
    rd("bp_w2", 32'h8, 32'h3333_3333);
    rd("bp_w3", 32'hC, 32'h4444_4444);
    tick();

    // Reset from RUN, then load the 3-word program; a core store during LOAD is ignored
    n_rst = 1'b0;
    program_counter = '0;
    tick();
    check_eq("rl_load_ready", {31'b0, load_ready}, 32'd1);
    check_eq("rl_core_held", {31'b0, core_n_rst}, 32'd0);
    check_eq("rl_fetch_nop", instruction, NOP);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_valid          = 1'b1;
      load_data           = prog[i];
      load_last           = (i == 2);
      memory_write_enable = (i == 0);
      memory_address      = 32'hC;
      memory_write_data   = 32'hFFFF_FFFF;
      tick();
    end
    load_valid          = 1'b0;
    load_last           = 1'b0;
    memory_write_enable = 1'b0;
    #1;
    check_eq("prog_ready_low", {31'b0, load_ready}, 32'd0);
    check_eq("prog_core_run", {31'b0, core_n_rst}, 32'd1);
    fetch("fetch_pc0", 32'h0, 32'h0010_0093);
    fetch("fetch_pc4", 32'h4, 32'h0000_0013);
    fetch("fetch_pc8", 32'h8, 32'h0000_006F);
    tick();
    rd("load_store_ignored", 32'hC, 32'h4444_4444);
    rd("oor_read", 32'h1000, 32'h0);
    fetch("oor_fetch_nop", 32'h1000, NOP);
    tick();

    // Stores, out-of-range store, read-during-write
    memory_write_enable = 1'b1;
    memory_address      = 32'h10;
    memory_write_data   = 32'h1234_5678;
    tick();
    memory_write_enable = 1'b0;
    rd("st_first", 32'h10, 32'h1234_5678);
    tick();
    memory_write_enable = 1'b1;
    memory_address      = 32'h1010;
    memory_write_data   = 32'hCAFE_0000;
    tick();
    memory_write_enable = 1'b0;
    rd("oor_store_ignored", 32'h10, 32'h1234_5678);
    tick();
    program_counter     = 32'h10;
    memory_write_enable = 1'b1;
    memory_write_data   = 32'hDEAD_BEEF;
    rd("rdw_old", 32'h10, 32'h1234_5678);
    check_eq("rdw_fetch_old", instruction, 32'h1234_5678);
    tick();
    memory_write_enable = 1'b0;
    rd("rdw_new", 32'h10, 32'hDEAD_BEEF);
    check_eq("rdw_fetch_new", instruction, 32'hDEAD_BEEF);
    tick();

    // MMIO overflow: second store to a full register is dropped
    mmio_out_ready      = 1'b0;
    memory_write_enable = 1'b1;
    memory_address      = MMIO_BASE;
    memory_write_data   = 32'h41;
    tick();
    check_eq("mmio_valid1", {31'b0, mmio_out_valid}, 32'd1);
    check_eq("mmio_data1", mmio_out_data, 32'h41);
    check_eq("mmio_ovf0", {31'b0, mmio_overflow}, 32'd0);
    memory_write_data = 32'h42;
    tick();
    memory_write_enable = 1'b0;
    check_eq("mmio_hold_data", mmio_out_data, 32'h41);
    check_eq("mmio_ovf1", {31'b0, mmio_overflow}, 32'd1);
    rd("mmio_status", MMIO_BASE + 32'd4, 32'h3);
    rd("mmio_rd_data", MMIO_BASE, 32'h41);
    tick();

    // Pop and capture in the same cycle, then a plain pop
    mmio_out_ready      = 1'b1;
    memory_write_enable = 1'b1;
    memory_address      = MMIO_BASE;
    memory_write_data   = 32'h43;
    tick();
    memory_write_enable = 1'b0;
    check_eq("popcap_valid", {31'b0, mmio_out_valid}, 32'd1);
    check_eq("popcap_data", mmio_out_data, 32'h43);
    tick();
    mmio_out_ready = 1'b0;
    check_eq("pop_valid0", {31'b0, mmio_out_valid}, 32'd0);
    check_eq("pop_ovf_sticky", {31'b0, mmio_overflow}, 32'd1);

    // Reset in RUN: RAM retained, loader restarts at word 0
    n_rst = 1'b0;
    program_counter = '0;
    tick();
    check_eq("rr_core_held", {31'b0, core_n_rst}, 32'd0);
    check_eq("rr_load_ready", {31'b0, load_ready}, 32'd1);
    check_eq("rr_fetch_nop", instruction, NOP);
    check_eq("rr_valid0", {31'b0, mmio_out_valid}, 32'd0);
    check_eq("rr_ovf0", {31'b0, mmio_overflow}, 32'd0);
    n_rst      = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'h0010_0093;
    load_last  = 1'b0;
    tick();
    load_data = 32'h1234_5678;
    load_last = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    #1;
    check_eq("rr_run", {31'b0, core_n_rst}, 32'd1);
    rd("rr_w0", 32'h0, 32'h0010_0093);
    rd("rr_w1_ptr0", 32'h4, 32'h1234_5678);
    rd("rr_w2_kept", 32'h8, 32'h0000_006F);
    tick();
    rd("rr_w3_kept", 32'hC, 32'h4444_4444);
    rd("rr_w4_kept", 32'h10, 32'hDEAD_BEEF);
    fetch("rr_fetch_pc0", 32'h0, 32'h0010_0093);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
